// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: round-robin arbiter with bounded grant hold.
// A granted requester keeps the resource while it requests, for at most
// MAX_HOLD consecutive cycles; ownership then rotates to the next requester
// in circular order with zero-cycle handover.
// Optional feature macro: ARB_LOCK_EN adds a LOCK input that lets the
// current owner exceed MAX_HOLD while it keeps requesting.
module rr_hold_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         REQ,
`ifdef ARB_LOCK_EN
    input  logic                 LOCK,
`endif
    output logic [N-1:0]         GNT,
    output logic [$clog2(N)-1:0] GNT_ID,
    output logic                 BUSY
);

    localparam int PW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_id_q, gnt_id_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          busy_q, busy_d;

    logic [PW-1:0] search_start;
    logic [PW-1:0] next_ptr;
    logic [PW-1:0] win_idx;
    logic [N-1:0]  win_onehot;
    logic          win_found;
    logic          owner_req;
    logic          at_limit;
    logic          lock_active;
    logic          release_now;

    assign owner_req = REQ[gnt_id_q];
    assign at_limit  = (cnt_q == 8'(MAX_HOLD));

`ifdef ARB_LOCK_EN
    // Lock only matters while the owner is still requesting.
    assign lock_active = LOCK & owner_req;
`else
    assign lock_active = 1'b0;
`endif

    assign release_now = (state_q == GRANT) && (!owner_req || (at_limit && !lock_active));

    // Pointer position just past the current owner, wrapping at N-1.
    assign next_ptr = (gnt_id_q == PW'(N - 1)) ? '0 : gnt_id_q + 1'b1;

    // On a release the search starts after the owner in the same edge,
    // so the outgoing owner is considered last.
    assign search_start = release_now ? next_ptr : ptr_q;

    // Circular scan of REQ starting at search_start; first set bit wins.
    always_comb begin
        logic [PW:0] pos;
        win_found = 1'b0;
        win_idx   = '0;
        pos       = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, search_start} + (PW + 1)'(k);
            if (pos >= (PW + 1)'(N)) begin
                pos = pos - (PW + 1)'(N);
            end
            if (!win_found && REQ[pos[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = pos[PW-1:0];
            end
        end
    end

    // One-hot decode of the search winner.
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign win_onehot[gi] = (win_idx == PW'(gi));
    end

    // Next-state logic: grant, hold, handover or return to idle.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d    = win_onehot;
                    gnt_id_d = win_idx;
                    busy_d   = 1'b1;
                    cnt_d    = 8'd1;
                    state_d  = GRANT;
                end else begin
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    busy_d   = 1'b0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d = next_ptr;
                    if (win_found) begin
                        gnt_d    = win_onehot;
                        gnt_id_d = win_idx;
                        busy_d   = 1'b1;
                        cnt_d    = 8'd1;
                    end else begin
                        gnt_d    = '0;
                        gnt_id_d = '0;
                        busy_d   = 1'b0;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end
                end else begin
                    // Saturate so a locked owner never wraps the counter.
                    cnt_d = at_limit ? cnt_q : cnt_q + 8'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    // State registers; reset overrides any grant in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
        end
    end

    assign GNT    = gnt_q;
    assign GNT_ID = gnt_id_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Testbench for rr_hold_arbiter (N=4, MAX_HOLD=4).
// Expected {GNT, GNT_ID, BUSY} tuples are queued when stimulus is driven and
// popped after the following rising edge for comparison.
module tb_rr_hold_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;
    localparam int PW = 2;
    localparam int EW = N + PW + 1;

    logic          clk;
    logic          reset;
    logic [N-1:0]  REQ;
    logic [N-1:0]  GNT;
    logic [PW-1:0] GNT_ID;
    logic          BUSY;
`ifdef ARB_LOCK_EN
    logic          LOCK;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] sb_q[$];

    rr_hold_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk    (clk),
        .reset  (reset),
        .REQ    (REQ),
`ifdef ARB_LOCK_EN
        .LOCK   (LOCK),
`endif
        .GNT    (GNT),
        .GNT_ID (GNT_ID),
        .BUSY   (BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build the expected output tuple for a given grant vector.
    function automatic logic [EW-1:0] mk_exp(input logic [N-1:0] g);
        logic [PW-1:0] id;
        id = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) id = PW'(i);
        end
        return {g, id, |g};
    endfunction

    // Drive inputs mid-cycle, away from the sampling edge.
    task automatic drive(input logic rst, input logic [N-1:0] req);
        @(negedge clk);
        reset = rst;
        REQ   = req;
    endtask

    task automatic do_reset();
        drive(1'b1, '0);
        @(posedge clk);
        #1;
    endtask

    // Shared by tests: advance one edge and settle.
    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [EW-1:0] exp, got;
        logic [N-1:0]  g;
        for (int c = 0; c < 3; c++) begin
            drive((c < 2) ? 1'b1 : 1'b0, 4'b1111);
            g = (c < 2) ? 4'b0000 : 4'b0001;
            sb_q.push_back(mk_exp(g));
            edge_settle();
            exp = sb_q.pop_front();
            got = {GNT, GNT_ID, BUSY};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset c%0d: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                         c, GNT, GNT_ID, BUSY, exp[EW-1:PW+1], exp[PW:1], exp[0]);
            end else begin
                $display("reset c%0d: gnt=%b id=%0d busy=%b ok", c, GNT, GNT_ID, BUSY);
            end
        end
    endtask

    task automatic test_full_load();
        logic [EW-1:0] exp, got;
        logic [N-1:0]  g;
        do_reset();
        for (int c = 0; c < 17; c++) begin
            drive(1'b0, 4'b1111);
            g = '0;
            g[(c / MH) % N] = 1'b1;
            sb_q.push_back(mk_exp(g));
            edge_settle();
            exp = sb_q.pop_front();
            got = {GNT, GNT_ID, BUSY};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL full_load c%0d: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                         c, GNT, GNT_ID, BUSY, exp[EW-1:PW+1], exp[PW:1], exp[0]);
            end else begin
                $display("full_load c%0d: gnt=%b id=%0d ok", c, GNT, GNT_ID);
            end
        end
    endtask

    task automatic test_single_requester();
        logic [EW-1:0] exp, got;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 4'b0100);
            sb_q.push_back(mk_exp(4'b0100));
            edge_settle();
            exp = sb_q.pop_front();
            got = {GNT, GNT_ID, BUSY};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL single c%0d: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                         c, GNT, GNT_ID, BUSY, exp[EW-1:PW+1], exp[PW:1], exp[0]);
            end else begin
                $display("single c%0d: gnt=%b id=%0d ok", c, GNT, GNT_ID);
            end
        end
    endtask

    task automatic test_early_release();
        logic [N-1:0]  reqs[4] = '{4'b0010, 4'b1101, 4'b0000, 4'b0011};
        logic [N-1:0]  gnts[4] = '{4'b0010, 4'b0100, 4'b0000, 4'b0001};
        logic [EW-1:0] exp, got;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, reqs[c]);
            sb_q.push_back(mk_exp(gnts[c]));
            edge_settle();
            exp = sb_q.pop_front();
            got = {GNT, GNT_ID, BUSY};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL early_release c%0d: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                         c, GNT, GNT_ID, BUSY, exp[EW-1:PW+1], exp[PW:1], exp[0]);
            end else begin
                $display("early_release c%0d: req=%b gnt=%b ok", c, reqs[c], GNT);
            end
        end
    endtask

    // Moves PTR to 2 with owner 3 at CNT=2, resets, and expects a restart from 0.
    task automatic test_reset_mid_grant();
        logic [N-1:0]  reqs[5] = '{4'b0010, 4'b1000, 4'b1000, 4'b1111, 4'b1111};
        logic          rsts[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [N-1:0]  gnts[5] = '{4'b0010, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        logic [EW-1:0] exp, got;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(rsts[c], reqs[c]);
            sb_q.push_back(mk_exp(gnts[c]));
            edge_settle();
            exp = sb_q.pop_front();
            got = {GNT, GNT_ID, BUSY};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid c%0d: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                         c, GNT, GNT_ID, BUSY, exp[EW-1:PW+1], exp[PW:1], exp[0]);
            end else begin
                $display("reset_mid c%0d: rst=%b req=%b gnt=%b ok", c, rsts[c], reqs[c], GNT);
            end
        end
    endtask

    // Owner drops REQ on the same edge its hold limit expires: PTR advances once.
    task automatic test_drop_at_limit();
        logic [N-1:0]  reqs[9] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1110,
                                   4'b1111, 4'b1111, 4'b1111, 4'b1111};
        logic [N-1:0]  gnts[9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                                   4'b0010, 4'b0010, 4'b0010, 4'b0100};
        logic [EW-1:0] exp, got;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(1'b0, reqs[c]);
            sb_q.push_back(mk_exp(gnts[c]));
            edge_settle();
            exp = sb_q.pop_front();
            got = {GNT, GNT_ID, BUSY};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL drop_at_limit c%0d: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                         c, GNT, GNT_ID, BUSY, exp[EW-1:PW+1], exp[PW:1], exp[0]);
            end else begin
                $display("drop_at_limit c%0d: req=%b gnt=%b ok", c, reqs[c], GNT);
            end
        end
    endtask

    // Random level-sensitive requests checked against a behavioural model.
    task automatic test_random();
        logic [EW-1:0] exp, got;
        logic [N-1:0]  req, g;
        bit            m_busy;
        int            m_owner, m_cnt, m_ptr, start, w;
        bit            rel;
        do_reset();
        m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        for (int c = 0; c < 200; c++) begin
            req = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = req | (N'(1) << m_owner);
            rel = m_busy && (!req[m_owner] || m_cnt == MH);
            if (rel) m_ptr = (m_owner + 1) % N;
            start = m_ptr;
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(start + k) % N]) w = (start + k) % N;
            end
            if (!m_busy || rel) begin
                if (w >= 0) begin
                    m_busy = 1; m_owner = w; m_cnt = 1;
                end else begin
                    m_busy = 0; m_owner = 0; m_cnt = 0;
                end
            end else begin
                m_cnt++;
            end
            g = m_busy ? (N'(1) << m_owner) : '0;
            drive(1'b0, req);
            sb_q.push_back(mk_exp(g));
            edge_settle();
            exp = sb_q.pop_front();
            got = {GNT, GNT_ID, BUSY};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random c%0d: req=%b got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                         c, req, GNT, GNT_ID, BUSY, exp[EW-1:PW+1], exp[PW:1], exp[0]);
            end else begin
                $display("random c%0d: req=%b gnt=%b ok", c, req, GNT);
            end
        end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        logic [EW-1:0] exp, got;
        logic [N-1:0]  g;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            drive(1'b0, 4'b1111);
            LOCK = (c < 10);
            g = (c < 10) ? 4'b0001 : 4'b0010;
            sb_q.push_back(mk_exp(g));
            edge_settle();
            exp = sb_q.pop_front();
            got = {GNT, GNT_ID, BUSY};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL lock c%0d: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                         c, GNT, GNT_ID, BUSY, exp[EW-1:PW+1], exp[PW:1], exp[0]);
            end else begin
                $display("lock c%0d: lock=%b gnt=%b ok", c, LOCK, GNT);
            end
        end
        LOCK = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1;
        REQ   = 4'b1111;
`ifdef ARB_LOCK_EN
        LOCK  = 1'b0;
`endif
        test_reset();
        test_full_load();
        test_single_requester();
        test_early_release();
        test_reset_mid_grant();
        test_drop_at_limit();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Round-robin arbiter with bounded grant hold. It shares one resource among N requesters and is the fair companion to the fixed-priority arbiter in the same library. A granted requester keeps ownership while it requests, up to MAX_HOLD consecutive cycles. Ownership then rotates to the next requester in circular order, with zero-cycle handover.

## Interface
- N, default 4: number of requesters, 2..16.
- MAX_HOLD, default 4: maximum consecutive cycles per grant, 1..255.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- REQ  input  N  request vector; bit i = requester i.
- GNT  output  N  registered one-hot grant, or all-zero.
- GNT_ID  output  $clog2(N)  index of current owner; 0 when idle.
- BUSY  output  1  high whenever GNT is non-zero.
- LOCK  input  1  present only with ARB_LOCK_EN; owner's request to exceed MAX_HOLD.

## Operation
- Internal state:
  - FSM states IDLE and GRANT.
  - Rotation pointer PTR, $clog2(N) bits.
  - Hold counter CNT, 8 bits.
- Search rule: scan REQ from bit PTR upward, wrapping at N-1 to 0. The first set bit wins.
- IDLE:
  - If |REQ at an edge: grant the search winner, CNT<=1, go to GRANT.
  - Otherwise GNT stays 0.
- GRANT, owner o. Release occurs when REQ[o]==0, or CNT==MAX_HOLD (and lock not active).
  - On release: PTR<=(o+1) mod N. The search uses this new PTR in the same edge.
  - Winner found: GNT<=winner one-hot, CNT<=1, stay in GRANT. This is a back-to-back handover with no idle cycle.
  - No winner: GNT<=0, GNT_ID<=0, go to IDLE.
  - No release: CNT<=CNT+1; GNT unchanged.
- Because the search starts at o+1, o is considered last. A sole remaining requester is re-granted immediately with CNT reset to 1.
- GNT is always one-hot or zero. GNT_ID and BUSY are always consistent with GNT.
- Requests are level-sensitive. The block has no request memory: a requester that drops REQ before being granted loses its turn.
- MAX_HOLD=1 gives per-cycle round-robin.

## Timing
- All outputs are registered.
- Latency: REQ sampled at edge k; GNT is valid after edge k, i.e. one cycle from REQ assertion to grant.
- Handover: the old owner's GNT falls and the new owner's GNT rises at the same edge.
- Reset values: GNT=0, GNT_ID=0, BUSY=0, PTR=0, CNT=0, state IDLE.
- Reset has priority over all other activity, including mid-grant. GNT drops at the first edge with reset=1, regardless of REQ.
- The first arbitration happens at the first edge with reset=0.
- If the owner drops REQ at the same edge CNT reaches MAX_HOLD, it is treated as a single release; PTR advances once.
- Simultaneous requests are resolved only by PTR order. There is no index priority beyond that.

## Configuration
- ARB_LOCK_EN defined:
  - Adds the LOCK port.
  - While LOCK=1 and REQ[o]=1, the MAX_HOLD limit is ignored and CNT saturates at MAX_HOLD.
  - Release happens only when REQ[o] drops, or when LOCK is low at an edge with CNT==MAX_HOLD.
  - LOCK is ignored in IDLE.
- ARB_LOCK_EN undefined: no LOCK port; the MAX_HOLD limit is always enforced.

## Test plan
- Reset: reset=1 for 2 cycles with REQ=4'b1111 -> GNT=0000, BUSY=0, GNT_ID=0. At the first edge after reset=0 -> GNT=0001.
- Steady full load, N=4, MAX_HOLD=4, REQ=1111 -> GNT sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again. No zero cycles.
- Single requester, REQ=0100 for 12 cycles -> GNT=0100 continuously. CNT wraps 4->1 with no gap. GNT_ID=2 throughout.
- Early release: owner 1 (GNT=0010); REQ changes to 1101 -> next edge GNT=0100. Then REQ=0000 -> next edge GNT=0000, BUSY=0. Next REQ=0011 -> GNT=0001, since PTR=3 and the search wraps to bit 0.
- Reset mid-grant: GNT=1000 with CNT=2, assert reset for 1 cycle -> GNT=0000. After release with REQ=1111 -> GNT=0001, confirming PTR was reset.
- (ARB_LOCK_EN) GNT=0001, LOCK=1, REQ=1111 for 10 cycles -> GNT stays 0001. Drop LOCK -> next edge GNT=0010.
